// File: rtl/clint_pkg.sv
// Shared offsets, register-select encoding and address decode for the core-local interruptor.
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFF    = 32'h0000_BFFC;
  localparam logic [31:0] CLINT_WINDOW_SIZE     = 32'h0000_C000;

  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi
  } reg_sel_e;

  // Word-aligned offset in, register select out; anything unmapped is RegNone.
  function automatic reg_sel_e clint_decode(input logic [31:0] off);
    case (off)
      CLINT_MSIP_OFF:        return RegMsip;
      CLINT_MTIMECMP_LO_OFF: return RegCmpLo;
      CLINT_MTIMECMP_HI_OFF: return RegCmpHi;
      CLINT_MTIME_LO_OFF:    return RegTimeLo;
      CLINT_MTIME_HI_OFF:    return RegTimeHi;
      default:               return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: pulses tick_o once every TICK_DIV cycles, phase restarts at 0 on reset.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [15:0] r_cnt;
  logic        w_tick;

  assign w_tick = (r_cnt == 16'(TICK_DIV - 1));
  assign tick_o = w_tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip on the data-bus slave port.
// Define CLINT_MTIME_WRITE_EN to make mtime lo/hi writable; otherwise mtime is read-only.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0200_0000),
  parameter int unsigned           TICK_DIV   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  request_i,
  input  logic                  we_i,
  input  logic [3:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  timer_irq_o,
  output logic                  software_irq_o
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_msip;
  logic                  r_timer_irq;

  logic                  w_tick;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_win;
  logic                  w_sel;
  logic                  w_wr;
  logic                  w_rd;
  reg_sel_e              w_reg;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  logic [63:0]           w_mtime_d;
  logic                  w_unused;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (w_tick)
  );

  assign w_off    = addr_i - BASE_ADDR;
  assign w_in_win = (addr_i >= BASE_ADDR) && (w_off < ADDR_WIDTH'(CLINT_WINDOW_SIZE));
  assign w_sel    = request_i & w_in_win;
  assign w_wr     = w_sel & we_i;
  assign w_rd     = w_sel & ~we_i;
  assign w_reg    = clint_decode(32'({w_off[ADDR_WIDTH-1:2], 2'b00}));
  assign w_wdata  = wdata_i[31:0];
  assign w_unused = ^{op_i, w_off[1:0]};

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_reg)
        RegMsip:   w_rdata = {31'b0, r_msip};
        RegCmpLo:  w_rdata = r_mtimecmp[31:0];
        RegCmpHi:  w_rdata = r_mtimecmp[63:32];
        RegTimeLo: w_rdata = r_mtime[31:0];
        RegTimeHi: w_rdata = r_mtime[63:32];
        default:   w_rdata = '0;
      endcase
    end
  end

  assign rdata_o        = DATA_WIDTH'(w_rdata);
  assign timer_irq_o    = r_timer_irq;
  assign software_irq_o = r_msip;

  // A write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    w_mtime_d = w_tick ? r_mtime + 64'd1 : r_mtime;
`ifdef CLINT_MTIME_WRITE_EN
    if (w_wr && (w_reg == RegTimeLo)) begin
      w_mtime_d = {r_mtime[63:32], w_wdata};
    end else if (w_wr && (w_reg == RegTimeHi)) begin
      w_mtime_d = {w_wdata, r_mtime[31:0]};
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_msip      <= 1'b0;
      r_timer_irq <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_mtime     <= w_mtime_d;
      if (w_wr) begin
        case (w_reg)
          RegMsip:  r_msip             <= w_wdata[0];
          RegCmpLo: r_mtimecmp[31:0]  <= w_wdata;
          RegCmpHi: r_mtimecmp[63:32] <= w_wdata;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: behavioural model predicts each cycle's outputs, a monitor compares.
module tb_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int unsigned TD   = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [3:0]  op;
  logic [31:0] addr, wdata, rdata;
  logic        tirq, sirq;

  logic        rst4, req4, we4;
  logic [3:0]  op4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        tirq4, sirq4;

  clint #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (TD)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .request_i      (req),
    .we_i           (we),
    .op_i           (op),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rdata_o        (rdata),
    .timer_irq_o    (tirq),
    .software_irq_o (sirq)
  );

  clint #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (4)
  ) u_dut4 (
    .clk_i          (clk),
    .rst_i          (rst4),
    .request_i      (req4),
    .we_i           (we4),
    .op_i           (op4),
    .addr_i         (addr4),
    .wdata_i        (wdata4),
    .rdata_o        (rdata4),
    .timer_irq_o    (tirq4),
    .software_irq_o (sirq4)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        tirq;
    logic        sirq;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: plain 64-bit values plus a cycles-since-reset count.
  logic [63:0]     m_time, m_cmp;
  logic            m_msip, m_irq;
  longint unsigned m_n;

  task automatic m_reset();
    m_time = 64'd0;
    m_cmp  = {64{1'b1}};
    m_msip = 1'b0;
    m_irq  = 1'b0;
    m_n    = 0;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0000_C000);
  endfunction

  function automatic logic [31:0] m_read(input logic q, input logic w, input logic [31:0] a);
    if (!q || w || !in_win(a)) return 32'd0;
    case ((a - BASE) & ~32'h3)
      32'h0000: return {31'b0, m_msip};
      32'h4000: return m_cmp[31:0];
      32'h4004: return m_cmp[63:32];
      32'hBFF8: return m_time[31:0];
      32'hBFFC: return m_time[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic r, input logic q, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    logic [63:0] nt;
    logic        nirq;
    bit          tick;
    if (r) begin
      m_reset();
    end else begin
      nirq = (m_time >= m_cmp);
      tick = ((m_n % TD) == TD - 1);
      m_n++;
      nt = tick ? m_time + 64'd1 : m_time;
      if (q && w && in_win(a)) begin
        case ((a - BASE) & ~32'h3)
          32'h0000: m_msip = d[0];
          32'h4000: m_cmp[31:0] = d;
          32'h4004: m_cmp[63:32] = d;
`ifdef CLINT_MTIME_WRITE_EN
          32'hBFF8: nt = {m_time[63:32], d};
          32'hBFFC: nt = {d, m_time[31:0]};
`endif
          default: ;
        endcase
      end
      m_time = nt;
      m_irq  = nirq;
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    rst   = r;
    req   = q;
    we    = w;
    addr  = a;
    wdata = d;
    op    = 4'($urandom);
    e.rdata = m_read(q, w, a);
    e.tirq  = m_irq;
    e.sirq  = m_msip;
    sb_q.push_back(e);
    m_step(r, q, w, a, d);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (rdata !== e.rdata || tirq !== e.tirq || sirq !== e.sirq) begin
        n_bad++;
        $display("FAIL vec%0d addr=%h we=%b: got rdata=%h tirq=%b sirq=%b, want rdata=%h tirq=%b sirq=%b",
                 n_vec, addr, we, rdata, tirq, sirq, e.rdata, e.tirq, e.sirq);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic        r, q, w;
    int          k;

    rst = 1'b1; req = 1'b0; we = 1'b0; op = 4'd0; addr = '0; wdata = '0;
    rst4 = 1'b1; req4 = 1'b1; we4 = 1'b0; op4 = 4'd0; addr4 = BASE + 32'hBFF8; wdata4 = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    drive(0, 1, 0, BASE + 32'h4000, 0);
    drive(0, 1, 0, BASE + 32'h4004, 0);
    drive(0, 1, 0, BASE + 32'h0000, 0);

    // msip write/read/clear.
    drive(0, 1, 1, BASE + 32'h0000, 32'hFFFF_FFFF);
    drive(0, 1, 0, BASE + 32'h0000, 0);
    drive(0, 1, 1, BASE + 32'h0000, 32'h0);
    drive(0, 1, 0, BASE + 32'h0000, 0);

    // Compare hit at mtime 10, then clear by moving mtimecmp hi.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, BASE + 32'h4004, 32'h0);
    drive(0, 1, 1, BASE + 32'h4000, 32'd10);
    repeat (14) drive(0, 1, 0, BASE + 32'hBFF8, 0);
    drive(0, 1, 1, BASE + 32'h4004, 32'hFFFF_FFFF);
    repeat (3) drive(0, 1, 0, BASE + 32'hBFF8, 0);

    // mtime write (takes effect only with CLINT_MTIME_WRITE_EN).
    drive(0, 1, 1, BASE + 32'hBFF8, 32'hFFFF_FFFF);
    drive(0, 1, 1, BASE + 32'hBFFC, 32'h0);
    drive(0, 1, 0, BASE + 32'hBFF8, 0);
    drive(0, 1, 0, BASE + 32'hBFFC, 0);
    drive(0, 1, 0, BASE + 32'hBFF8, 0);
    drive(0, 1, 0, BASE + 32'hBFFC, 0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      case (k)
        0: a = BASE + 32'h0000;
        1: a = BASE + 32'h4000;
        2: a = BASE + 32'h4004;
        3: a = BASE + 32'hBFF8;
        4: a = BASE + 32'hBFFC;
        5: a = BASE + 32'h0100;
        6: a = BASE - 32'd4;
        7: a = BASE + 32'hC000;
        8: a = $urandom;
        default: a = BASE + 32'h4008;
      endcase
      if (k != 8) a = a | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = m_time[31:0] + 32'($urandom_range(0, 16));
        2: d = 32'h0;
        default: d = 32'hFFFF_FFFF;
      endcase
      drive(r, q, w, a, d);
    end
    req = 1'b0;

    // Prescaled instance: mtime lo reads k/4 on cycle k after reset.
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_vec++;
      if (rdata4 !== 32'(c / 4) || tirq4 !== 1'b0 || sirq4 !== 1'b0) begin
        n_bad++;
        $display("FAIL div4_cycle%0d: got mtime_lo=%0d tirq=%b sirq=%b, want mtime_lo=%0d tirq=0 sirq=0",
                 c, rdata4, tirq4, sirq4, c / 4);
      end
      @(posedge clk);
      #1;
    end

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
